// File: rtl/pixel_streamer.sv
// ---------------------------------------------------------------------------
// pixel_streamer
//
// Streams a block of image-memory words out as a sequence of pixels.
// Each memory word holds four pixels, most significant pixel first.
// A word is read through a combinational read port, held in a local
// register and sent one pixel per accepted valid/ready handshake. When the
// last pixel of a word is accepted and more words remain, the next word is
// fetched on that same edge, so a ready sink sees one pixel per cycle with
// no gaps between words.
//
// Optional feature (compile-time macro PIXEL_STREAMER_LAST_EN):
//   adds output out_last, high while the final pixel of the block is shown.
//
// Parameters
//   ADDR_W       memory word-address width (2**ADDR_W words)
//   PIX_W        pixel width; a memory word is 4*PIX_W bits
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   start        one-cycle block request, ignored while busy
//   base_addr    first word address of the block (sampled with start)
//   word_count   number of words in the block, 0..2**ADDR_W
//   mem_addr     word address to image memory (always the word pointer)
//   mem_rd_data  combinational read data for mem_addr
//   out_pixel    streamed pixel
//   out_valid    out_pixel is valid
//   out_ready    sink accepts the pixel on this edge
//   busy         high from start acceptance until the done cycle ends
//   done         one-cycle pulse after the final pixel transfer
//   out_last     (PIXEL_STREAMER_LAST_EN only) final pixel of the block
// ---------------------------------------------------------------------------
module pixel_streamer #(
    parameter int ADDR_W = 7,
    parameter int PIX_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      word_count,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [4*PIX_W-1:0]   mem_rd_data,
    output logic [PIX_W-1:0]     out_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
`ifdef PIXEL_STREAMER_LAST_EN
    ,
    output logic                 out_last
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StFin
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    ptr;        // next word to fetch
    logic [ADDR_W:0]      remaining;  // words not yet fetched
    logic [4*PIX_W-1:0]   hold;       // word currently being sent
    logic [1:0]           idx;        // pixel index within hold, 0 = MSB pixel

    // Select pixel i of a word; pixel 0 sits in the most significant bits.
    function automatic logic [PIX_W-1:0] pick(input logic [4*PIX_W-1:0] w,
                                              input logic [1:0]         i);
        logic [PIX_W-1:0] p;
        p = '0;
        case (i)
            2'd0:    p = w[4*PIX_W-1 -: PIX_W];
            2'd1:    p = w[3*PIX_W-1 -: PIX_W];
            2'd2:    p = w[2*PIX_W-1 -: PIX_W];
            default: p = w[PIX_W-1   -: PIX_W];
        endcase
        return p;
    endfunction

    // The pointer is the address; no separate address register to keep in sync.
    assign mem_addr = ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            ptr       <= '0;
            remaining <= '0;
            hold      <= '0;
            idx       <= '0;
            out_pixel <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PIXEL_STREAMER_LAST_EN
            out_last  <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        ptr       <= base_addr;
                        remaining <= word_count;
                        if (word_count != '0) begin
                            state <= StLoad;
                        end else begin
                            // Empty block: skip straight to the done cycle.
                            state <= StFin;
                            done  <= 1'b1;
                        end
                    end
                end

                StLoad: begin
                    hold      <= mem_rd_data;
                    ptr       <= ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    idx       <= 2'd0;
                    out_pixel <= pick(mem_rd_data, 2'd0);
                    out_valid <= 1'b1;
                    state     <= StSend;
`ifdef PIXEL_STREAMER_LAST_EN
                    out_last  <= 1'b0;
`endif
                end

                StSend: begin
                    // Outputs only move on a transfer, so they stay stable under backpressure.
                    if (out_ready) begin
                        if (idx != 2'd3) begin
                            idx       <= idx + 2'd1;
                            out_pixel <= pick(hold, idx + 2'd1);
`ifdef PIXEL_STREAMER_LAST_EN
                            // Next pixel is pixel 3; it is final if no words remain.
                            out_last  <= (idx == 2'd2) && (remaining == '0);
`endif
                        end else if (remaining != '0) begin
                            // Fetch the next word on the same edge: no bubble.
                            hold      <= mem_rd_data;
                            ptr       <= ptr + 1'b1;
                            remaining <= remaining - 1'b1;
                            idx       <= 2'd0;
                            out_pixel <= pick(mem_rd_data, 2'd0);
`ifdef PIXEL_STREAMER_LAST_EN
                            out_last  <= 1'b0;
`endif
                        end else begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= StFin;
`ifdef PIXEL_STREAMER_LAST_EN
                            out_last  <= 1'b0;
`endif
                        end
                    end
                end

                StFin: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end

                default: begin
                    state     <= StIdle;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
